// File: rtl/burst_arb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// burst_arb_ctrl_pkg
// Shared definitions for the burst arbiter slice:
//   - default sizing (requester count, burst-length width, watchdog limit)
//   - FSM state encoding
//   - one-hot to index conversion used to derive the owner index from a grant
// No ports; imported by the interface, the winner search and the top.
// -----------------------------------------------------------------------------
package burst_arb_ctrl_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_TMO   = 15;

  // owner is a fixed 2-bit port, so at most four requesters can be indexed
  localparam int OWN_W    = 2;
  localparam int MAX_NREQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // OR-combine the indices of all set bits; for a one-hot input this is the
  // index of the single set bit, and for all-zero it returns 0.
  function automatic logic [OWN_W-1:0] onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
    logic [OWN_W-1:0] idx;
    idx = {OWN_W{1'b0}};
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (oh[i]) begin
        idx = idx | OWN_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/burst_arb_ctrl_if.sv
// -----------------------------------------------------------------------------
// burst_arb_ctrl_if
// Request/grant bundle between the requesters (plus shared-resource beat
// feedback) and the burst arbiter.
//   prior : 1 = fixed priority, 0 = round robin (sampled at arbitration)
//   req   : per-requester level request
//   len   : per-requester burst length minus one, slice i = len[i*LEN_W +: LEN_W]
//   beat  : the shared resource accepted one beat this cycle
//   grant : registered one-hot grant or all-zero
//   owner : index of the current or most recent grantee
//   busy  : any grant bit set
//   last  : busy and no beats remain after the current one
//   abort : one-cycle pulse when the watchdog kills a burst
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface burst_arb_ctrl_if
  import burst_arb_ctrl_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int LEN_W = DEF_LEN_W
);

  logic                    prior;
  logic [NREQ-1:0]         req;
  logic [NREQ*LEN_W-1:0]   len;
  logic                    beat;
  logic [NREQ-1:0]         grant;
  logic [OWN_W-1:0]        owner;
  logic                    busy;
  logic                    last;
  logic                    abort;

  modport master (
    output prior, req, len, beat,
    input  grant, owner, busy, last, abort
  );

  modport slave (
    input  prior, req, len, beat,
    output grant, owner, busy, last, abort
  );

endinterface

// File: rtl/burst_arb_ctrl_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational winner search for the burst arbiter.
//   req   : in,  NREQ   - asserted requests
//   ptr   : in,  OWN_W  - index of the last completed/aborted grantee
//   prior : in,  1      - 1 = lowest index wins, 0 = search upward from ptr+1
//   win   : out, NREQ   - one-hot winner, all-zero when nothing requests
//   valid : out, 1      - a winner was found
// -----------------------------------------------------------------------------
module rr_pick
  import burst_arb_ctrl_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]  req,
  input  logic [OWN_W-1:0] ptr,
  input  logic             prior,
  output logic [NREQ-1:0]  win,
  output logic             valid
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic             found;
  logic [IDX_W-1:0] idx;

  // Scan candidates in priority order and keep only the first hit, which
  // guarantees win is one-hot by construction.
  always_comb begin
    win   = {NREQ{1'b0}};
    found = 1'b0;
    idx   = {IDX_W{1'b0}};
    if (prior) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i]) begin
          win[i] = 1'b1;
          found  = 1'b1;
        end else begin
          found = found;
        end
      end
    end else begin
      // k runs 1..NREQ so the previous grantee is considered last
      for (int k = 1; k <= NREQ; k++) begin
        idx = IDX_W'((int'(ptr) + k) % NREQ);
        if (!found && req[idx]) begin
          win[idx] = 1'b1;
          found    = 1'b1;
        end else begin
          found = found;
        end
      end
    end
    valid = found;
  end

endmodule

// File: rtl/burst_arb_ctrl.sv
// -----------------------------------------------------------------------------
// burst_arb_ctrl
// Burst-oriented arbiter for a shared resource. One requester at a time owns
// the resource for len+1 accepted beats; the burst also ends early when the
// owner drops its request or when no beat arrives for TMO cycles (watchdog
// abort). Every release is followed by a one-cycle turnaround gap.
// Ports:
//   clk : in  - clock, rising edge
//   rst : in  - asynchronous active-high reset
//   bus : slave modport of burst_arb_ctrl_if (prior/req/len/beat in,
//         grant/owner/busy/last/abort out)
// -----------------------------------------------------------------------------
module burst_arb_ctrl
  import burst_arb_ctrl_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int LEN_W = DEF_LEN_W,
  parameter int TMO   = DEF_TMO
) (
  input  logic             clk,
  input  logic             rst,
  burst_arb_ctrl_if.slave  bus
);

  localparam int WD_W = (TMO > 0) ? $clog2(TMO + 1) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [NREQ-1:0]   grant_vec;
  logic [NREQ-1:0]   grant_nxt;
  logic [OWN_W-1:0]  owner_idx;
  logic [OWN_W-1:0]  owner_nxt;
  logic [OWN_W-1:0]  ptr;
  logic [OWN_W-1:0]  ptr_nxt;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  cnt_nxt;
  logic [WD_W-1:0]   wdog;
  logic [WD_W-1:0]   wdog_nxt;
  logic              abort_pulse;
  logic              abort_nxt;

  logic [NREQ-1:0]     pick_win;
  logic                pick_valid;
  logic [MAX_NREQ-1:0] pick_ext;
  logic [OWN_W-1:0]    pick_idx;
  logic [LEN_W-1:0]    pick_len;
  logic                owner_req;
  logic [WD_W:0]       wdog_inc;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .prior (bus.prior),
    .win   (pick_win),
    .valid (pick_valid)
  );

  // Winner index and its burst length, selected with constant slices only.
  always_comb begin
    pick_ext           = {MAX_NREQ{1'b0}};
    pick_ext[NREQ-1:0] = pick_win;
    pick_idx           = onehot_to_idx(pick_ext);
    pick_len           = {LEN_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (pick_win[i]) begin
        pick_len = pick_len | bus.len[i*LEN_W +: LEN_W];
      end else begin
        pick_len = pick_len;
      end
    end
  end

  // The owner's own request line, and the watchdog value it would reach.
  always_comb begin
    owner_req = |(bus.req & grant_vec);
    wdog_inc  = {1'b0, wdog} + {{WD_W{1'b0}}, 1'b1};
  end

  // State register and all datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant_vec   <= {NREQ{1'b0}};
      owner_idx   <= {OWN_W{1'b0}};
      ptr         <= OWN_W'(NREQ - 1);
      cnt         <= {LEN_W{1'b0}};
      wdog        <= {WD_W{1'b0}};
      abort_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant_vec   <= grant_nxt;
      owner_idx   <= owner_nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      wdog        <= wdog_nxt;
      abort_pulse <= abort_nxt;
    end
  end

  // Next-state and next-register logic; every branch starts from "hold".
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_vec;
    owner_nxt = owner_idx;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    wdog_nxt  = wdog;
    abort_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        // prior is consumed only here, through rr_pick
        if (pick_valid) begin
          grant_nxt = pick_win;
          owner_nxt = pick_idx;
          cnt_nxt   = pick_len;
          wdog_nxt  = {WD_W{1'b0}};
          state_nxt = ST_BUSY;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_BUSY: begin
        if (bus.beat) begin
          // an accepted beat always counts, even if the owner lets go now
          wdog_nxt = {WD_W{1'b0}};
          if ((cnt == {LEN_W{1'b0}}) || !owner_req) begin
            grant_nxt = {NREQ{1'b0}};
            ptr_nxt   = owner_idx;
            cnt_nxt   = {LEN_W{1'b0}};
            state_nxt = ST_GAP;
          end else begin
            cnt_nxt = cnt - {{(LEN_W-1){1'b0}}, 1'b1};
          end
        end else if (wdog_inc == (WD_W+1)'(TMO)) begin
          // watchdog wins over a simultaneous request drop
          abort_nxt = 1'b1;
          wdog_nxt  = WD_W'(TMO);
          grant_nxt = {NREQ{1'b0}};
          ptr_nxt   = owner_idx;
          cnt_nxt   = {LEN_W{1'b0}};
          state_nxt = ST_GAP;
        end else if (!owner_req) begin
          grant_nxt = {NREQ{1'b0}};
          ptr_nxt   = owner_idx;
          cnt_nxt   = {LEN_W{1'b0}};
          state_nxt = ST_GAP;
        end else begin
          wdog_nxt = wdog_inc[WD_W-1:0];
        end
      end

      ST_GAP: begin
        // one turnaround cycle with nothing granted
        grant_nxt = {NREQ{1'b0}};
        state_nxt = ST_IDLE;
      end

      default: begin
        grant_nxt = {NREQ{1'b0}};
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.grant = grant_vec;
  assign bus.owner = owner_idx;
  assign bus.busy  = |grant_vec;
  assign bus.last  = (|grant_vec) && (cnt == {LEN_W{1'b0}});
  assign bus.abort = abort_pulse;

endmodule

// File: tb/tb_burst_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_burst_arb_ctrl
// Self-checking bench for burst_arb_ctrl: a table of per-cycle vectors for
// round-robin rotation and fixed priority, then hand-written sequences for
// burst length, watchdog abort, early request drop and mid-burst reset.
// Inputs are driven just after the falling edge; outputs are compared 1
// time unit later, i.e. they reflect the registers loaded at the previous
// rising edge.
// -----------------------------------------------------------------------------
module tb_burst_arb_ctrl;
  import burst_arb_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  burst_arb_ctrl_if #(.NREQ(4), .LEN_W(4)) bus ();

  burst_arb_ctrl #(
    .NREQ  (4),
    .LEN_W (4),
    .TMO   (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        prior;
    logic [3:0]  req;
    logic [15:0] len;
    logic        beat;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic        last;
    logic        abort;
  } vec_t;

  localparam int NVEC = 29;
  vec_t tbl [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(input logic p, input logic [3:0] r, input logic b,
                              input logic [3:0] g, input logic [1:0] o, input logic ls);
    vec_t v;
    v.prior = p;
    v.req   = r;
    v.len   = 16'h0000;
    v.beat  = b;
    v.grant = g;
    v.owner = o;
    v.busy  = |g;
    v.last  = ls;
    v.abort = 1'b0;
    return v;
  endfunction

  task automatic drive(input logic p, input logic [3:0] r, input logic [15:0] l, input logic b);
    bus.prior = p;
    bus.req   = r;
    bus.len   = l;
    bus.beat  = b;
  endtask

  task automatic expect_out(input string tag, input int cyc, input logic [3:0] g,
                            input logic [1:0] o, input logic bz, input logic ls, input logic ab);
    logic [8:0] act;
    logic [8:0] exp;
    act = {bus.grant, bus.owner, bus.busy, bus.last, bus.abort};
    exp = {g, o, bz, ls, ab};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got grant=%b owner=%0d busy=%b last=%b abort=%b, want grant=%b owner=%0d busy=%b last=%b abort=%b",
               tag, cyc, bus.grant, bus.owner, bus.busy, bus.last, bus.abort, g, o, bz, ls, ab);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // rotation: prior=0, req=1111, len=0, beat high (beat in IDLE/GAP ignored)
    tbl[0]  = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    tbl[1]  = mk(1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
    tbl[2]  = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    tbl[3]  = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    tbl[4]  = mk(1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1);
    tbl[5]  = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0);
    tbl[6]  = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0);
    tbl[7]  = mk(1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1);
    tbl[8]  = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0);
    tbl[9]  = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0);
    tbl[10] = mk(1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1);
    tbl[11] = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0);
    tbl[12] = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0);
    tbl[13] = mk(1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
    tbl[14] = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    // fixed priority: req=1111 keeps granting 0
    tbl[15] = mk(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    tbl[16] = mk(1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
    tbl[17] = mk(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    tbl[18] = mk(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    tbl[19] = mk(1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
    // fixed priority: req=1110 keeps granting 1 (round robin would pick 2)
    tbl[20] = mk(1'b1, 4'b1110, 1'b1, 4'b0000, 2'd0, 1'b0);
    tbl[21] = mk(1'b1, 4'b1110, 1'b1, 4'b0000, 2'd0, 1'b0);
    tbl[22] = mk(1'b1, 4'b1110, 1'b1, 4'b0010, 2'd1, 1'b1);
    tbl[23] = mk(1'b1, 4'b1110, 1'b1, 4'b0000, 2'd1, 1'b0);
    tbl[24] = mk(1'b1, 4'b1110, 1'b1, 4'b0000, 2'd1, 1'b0);
    tbl[25] = mk(1'b1, 4'b1110, 1'b1, 4'b0010, 2'd1, 1'b1);
    // no requests: stays idle, owner keeps last grantee, beats ignored
    tbl[26] = mk(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0);
    tbl[27] = mk(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0);
    tbl[28] = mk(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0);

    rst = 1'b1;
    drive(1'b0, 4'b0000, 16'h0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    expect_out("reset", 0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(tbl[i].prior, tbl[i].req, tbl[i].len, tbl[i].beat);
      #1;
      expect_out("table", i, tbl[i].grant, tbl[i].owner, tbl[i].busy, tbl[i].last, tbl[i].abort);
    end

    // burst of 4 beats for requester 2, beat every other cycle (c2,c4,c6,c8)
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      drive(1'b0, 4'b0100, 16'h0300, (c >= 2) && (c <= 8) && ((c % 2) == 0));
      #1;
      if (c == 0) begin
        expect_out("burst", c, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
      end else if (c <= 8) begin
        expect_out("burst", c, 4'b0100, 2'd2, 1'b1, (c >= 7), 1'b0);
      end else begin
        expect_out("burst", c, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
      end
    end

    // watchdog abort on requester 0, then round robin resumes at 1,
    // then requester 3 drops its request after 2 of 8 beats
    for (int c = 10; c <= 34; c++) begin
      logic [3:0]  r;
      logic [15:0] l;
      logic        b;
      r = (c < 26) ? 4'b0001 : (c < 29) ? 4'b1111 : (c < 33) ? 4'b1000 : 4'b0000;
      l = (c < 26) ? 16'h0005 : (c < 29) ? 16'h0000 : 16'h7000;
      b = ((c >= 26) && (c < 29)) || (c == 31) || (c == 32);
      @(negedge clk);
      drive(1'b0, r, l, b);
      #1;
      if (c == 10) begin
        expect_out("wdog", c, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
      end else if (c <= 25) begin
        expect_out("wdog", c, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
      end else if (c == 26) begin
        expect_out("wdog_abort", c, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
      end else if (c == 27) begin
        expect_out("wdog_gap", c, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
      end else if (c == 28) begin
        expect_out("rr_after_abort", c, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
      end else if (c <= 30) begin
        expect_out("drop", c, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
      end else if (c <= 33) begin
        expect_out("drop", c, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
      end else begin
        expect_out("drop_release", c, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);
      end
    end

    // reset in the middle of a long burst for requester 2
    for (int c = 35; c <= 37; c++) begin
      @(negedge clk);
      drive(1'b0, 4'b0100, 16'h0F00, 1'b0);
      #1;
      if (c == 35) begin
        expect_out("pre_rst", c, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);
      end else begin
        expect_out("pre_rst", c, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
      end
    end
    #1;
    rst = 1'b1;
    #1;
    expect_out("rst_async", 38, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    expect_out("rst_held", 39, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 4'b1111, 16'h0000, 1'b0);
    #1;
    expect_out("post_rst_idle", 40, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    expect_out("post_rst_grant", 41, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
